qrs_peak_tracker: RTL
=====================

# qrs_peak_tracker

Streaming, single-clock, parametrised R-peak detector for the ECG chain. It replaces the divided-clock chain of inverse Haar transform, detail-coefficient max finder and address remapper with one pipeline. The pipeline computes a level-`LEVEL` Haar detail coefficient on the fly and locates the peak coefficient per decision window against an adaptive threshold. It refines each detection to the raw-sample maximum inside the winning block and enforces a refractory period. It sits directly on the sample stream `x` and drives the beat-address consumer.

## Interface
- `DATA_W`, default 16: signed sample width.
- `ADDR_W`, default 32: sample-index width.
- `LEVEL`, default 3, min 1: Haar level. Block length B = 2^LEVEL.
- `WIN_BLOCKS`, default 4, min 1: coefficients per decision window.
- `REFRACT_BLOCKS`, default 2, min 0: coefficients ignored after a detection.
- `INIT_THR`, default 64: threshold value after reset.
- Derived: CW = DATA_W+LEVEL.
- `clock_iht`  in  1: sole clock, rising edge.
- `reset`  in  1: synchronous, active-high.
- `x_valid`  in  1: `x` is accepted on this cycle.
- `x`  in  DATA_W: signed ECG sample.
- `coef_valid`  out  1: one-cycle strobe, new detail coefficient.
- `coef`  out  CW: signed detail coefficient, S1−S2.
- `peak_valid`  out  1: one-cycle strobe, R peak detected.
- `peak_addr`  out  ADDR_W: sample index of the R peak.
- `peak_amp`  out  DATA_W: raw sample value at `peak_addr`.
- `thr`  out  CW: current adaptive threshold, unsigned.

## Operation
**Sample indexing**
- `samp_idx` is ADDR_W bits and starts at 0. Each accepted sample takes the current `samp_idx`, then `samp_idx` increments, wrapping mod 2^ADDR_W.
- When `x_valid`=0, all state holds.

**Block accumulation**
- A LEVEL-bit phase counter tracks position in the block.
- S1 sums accepted samples at phases 0..B/2−1; S2 sums phases B/2..B−1. Sign-extend every sample to CW bits.
- Within the block, track raw max `x` and its index. On a tie, keep the first occurrence.
- On the sample at phase B−1, register `coef` = S1−S2 and `mag` = |coef| (unsigned CW, never overflows). Register the block's raw max and index alongside. Clear the accumulators for the next block.

**Detection FSM**
- States are SEARCH and REFRACT. Reset enters SEARCH with window count 0, `best_mag` 0 and `found` 0.
- SEARCH, on each coefficient:
  - If `mag` ≥ (thr>>1) and `mag` > `best_mag` (strict), set `found`=1 and latch `mag`, raw index and raw max.
  - Increment the window count. The window-closing coefficient is evaluated before the decision.
- Window end (count = WIN_BLOCKS):
  - If `found`: pulse `peak_valid` with the latched addr/amp, set thr ← (thr + best_mag)>>1 using a CW+1-bit sum, then go to REFRACT if REFRACT_BLOCKS>0, else stay in SEARCH.
  - If not `found`: thr ← thr − (thr>>2), no pulse.
  - In both cases, clear count, `best_mag` and `found`.
- REFRACT: coefficients are counted but not evaluated. After REFRACT_BLOCKS coefficients, return to SEARCH with a fresh window.
- Threshold floor: thr never decays below 1.

## Timing
- All outputs are 0 in reset except `thr` = INIT_THR.
- `coef_valid` pulses on the cycle after the phase-B−1 sample is accepted.
- `peak_valid` pulses on the cycle after the window-closing `coef_valid`, i.e. 2 cycles after the last sample of the window. `thr` updates in that same cycle.
- `peak_addr`/`peak_amp` hold until the next `peak_valid`. `coef` holds until the next `coef_valid`.
- Accepting samples back-to-back every cycle is supported with no stall.
- Reset mid-block or mid-window discards partial sums, window and refractory state. The first post-reset sample is index 0, phase 0.
- The window-end decision and a new sample acceptance in the same cycle are independent. The new sample belongs to the next block.
- `peak_addr` is the wrapped index. Blocks straddling the wrap are handled normally.

## Test plan
- Reset with any prior state → next cycle all outputs 0, `thr`=64, and the first coefficient appears after 8 accepted samples.
- Defaults, constant x=100 for 32 samples → 4 `coef_valid` with coef=0, no `peak_valid`, `thr` 64→48 one cycle after the 4th coefficient.
- Zeros except x=1000 at index 10 → coef=1000 for block 1, `peak_valid` 2 cycles after sample 31 with addr=10, amp=1000, thr=532.
- Continue from the previous scenario with x=1000 at index 36 (refractory block 4) → no peak. Then x=1000 at index 50 (window starting block 6) → that window closes with a peak at addr 50 and thr=766.
- Fresh reset, x=500 at indices 1 and 17 (blocks 0 and 2, equal mag) → peak addr=1. Also x=−700 at index 5 alone → coef=+700, peak addr=… raw max index per first-occurrence rule (0, value 0).
- Random `x_valid` gaps, with reset asserted at phase 5 of block 2 → coef sequence and peak addresses match a gap-free golden model, restarting from index 0.

Source files
------------

// File: rtl/qrs_peak_tracker.sv
// ---------------------------------------------------------------------------
// qrs_peak_tracker
//
// Single-clock streaming R-peak detector. The design computes a level-LEVEL
// Haar detail coefficient on the fly, one per block of B = 2^LEVEL accepted
// samples. It then picks the strongest coefficient in each decision window
// of WIN_BLOCKS coefficients against an adaptive threshold. A detection
// reports the raw-sample maximum inside the winning block. A refractory
// period of REFRACT_BLOCKS coefficients follows each detection.
//
// Pipeline:
//   stage 1 (sample edge)  : phase/index counters, S1/S2 sums, per-block raw
//                            max; registers coef, |coef| and block max at the
//                            last sample of the block.
//   stage 2 (coef edge)    : SEARCH/REFRACT FSM, window bookkeeping, peak
//                            strobe and threshold update.
//
// Ports:
//   clock_iht   in   1        sole clock, rising edge
//   reset       in   1        synchronous, active-high
//   x_valid     in   1        x is accepted this cycle
//   x           in   DATA_W   signed ECG sample
//   coef_valid  out  1        one-cycle strobe, new detail coefficient
//   coef        out  CW       signed detail coefficient S1 - S2
//   peak_valid  out  1        one-cycle strobe, R peak detected
//   peak_addr   out  ADDR_W   sample index of the R peak (wrapped)
//   peak_amp    out  DATA_W   raw sample value at peak_addr
//   thr         out  CW       current adaptive threshold (unsigned)
// ---------------------------------------------------------------------------
module qrs_peak_tracker #(
    parameter int unsigned DATA_W         = 16,
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned LEVEL          = 3,
    parameter int unsigned WIN_BLOCKS     = 4,
    parameter int unsigned REFRACT_BLOCKS = 2,
    parameter int unsigned INIT_THR       = 64
) (
    input  logic                             clock_iht,
    input  logic                             reset,
    input  logic                             x_valid,
    input  logic signed [DATA_W-1:0]         x,
    output logic                             coef_valid,
    output logic signed [DATA_W+LEVEL-1:0]   coef,
    output logic                             peak_valid,
    output logic        [ADDR_W-1:0]         peak_addr,
    output logic signed [DATA_W-1:0]         peak_amp,
    output logic        [DATA_W+LEVEL-1:0]   thr
);

    localparam int unsigned CW      = DATA_W + LEVEL;
    localparam int unsigned CNT_MAX = (WIN_BLOCKS > REFRACT_BLOCKS) ? WIN_BLOCKS
                                                                     : REFRACT_BLOCKS;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(WIN_BLOCKS - 1);
    localparam logic [CNT_W-1:0] REF_LAST =
        CNT_W'((REFRACT_BLOCKS > 0) ? (REFRACT_BLOCKS - 1) : 0);
    localparam logic [CW-1:0]    THR_RST  = CW'(INIT_THR);
    localparam logic [CW-1:0]    THR_MIN  = CW'(1);

    // -----------------------------------------------------------------------
    // Stage 1: block accumulation
    // -----------------------------------------------------------------------
    logic        [ADDR_W-1:0] samp_idx_q;
    logic        [LEVEL-1:0]  phase_q;
    logic signed [CW-1:0]     s1_q;
    logic signed [CW-1:0]     s2_q;
    logic signed [DATA_W-1:0] run_max_q;
    logic        [ADDR_W-1:0] run_idx_q;

    logic                     coef_valid_q;
    logic signed [CW-1:0]     coef_q;
    logic        [CW-1:0]     mag_q;
    logic signed [DATA_W-1:0] blk_max_q;
    logic        [ADDR_W-1:0] blk_idx_q;

    logic signed [CW-1:0]     x_ext;
    logic signed [CW-1:0]     s1_sum;
    logic signed [CW-1:0]     s2_sum;
    logic signed [CW-1:0]     coef_new;
    logic        [CW-1:0]     mag_new;
    logic                     phase_last;
    logic                     first_half;
    logic                     take_new;
    logic signed [DATA_W-1:0] blk_max_new;
    logic        [ADDR_W-1:0] blk_idx_new;

    always_comb begin
        x_ext      = {{LEVEL{x[DATA_W-1]}}, x};
        phase_last = &phase_q;
        first_half = ~phase_q[LEVEL-1];
        s1_sum     = s1_q + x_ext;
        s2_sum     = s2_q + x_ext;
        // The last sample of a block always lands in the second half.
        coef_new   = s1_q - s2_sum;
        // |coef| fits in CW unsigned bits since coef never reaches -2^(CW-1).
        mag_new    = coef_new[CW-1] ? CW'(~coef_new + CW'(1)) : CW'(coef_new);
        // Strict compare keeps the first occurrence on ties.
        take_new    = (phase_q == '0) || (x > run_max_q);
        blk_max_new = take_new ? x : run_max_q;
        blk_idx_new = take_new ? samp_idx_q : run_idx_q;
    end

    always_ff @(posedge clock_iht) begin
        if (reset) begin
            samp_idx_q   <= '0;
            phase_q      <= '0;
            s1_q         <= '0;
            s2_q         <= '0;
            run_max_q    <= '0;
            run_idx_q    <= '0;
            coef_valid_q <= 1'b0;
            coef_q       <= '0;
            mag_q        <= '0;
            blk_max_q    <= '0;
            blk_idx_q    <= '0;
        end else begin
            coef_valid_q <= 1'b0;
            if (x_valid) begin
                samp_idx_q <= samp_idx_q + ADDR_W'(1);
                phase_q    <= phase_q + LEVEL'(1);
                if (phase_last) begin
                    coef_valid_q <= 1'b1;
                    coef_q       <= coef_new;
                    mag_q        <= mag_new;
                    blk_max_q    <= blk_max_new;
                    blk_idx_q    <= blk_idx_new;
                    s1_q         <= '0;
                    s2_q         <= '0;
                end else begin
                    if (first_half) begin
                        s1_q <= s1_sum;
                    end else begin
                        s2_q <= s2_sum;
                    end
                    run_max_q <= blk_max_new;
                    run_idx_q <= blk_idx_new;
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Stage 2: detection FSM
    // -----------------------------------------------------------------------
    typedef enum logic {
        StSearch,
        StRefract
    } det_state_e;

    det_state_e               state_q,      state_d;
    logic        [CNT_W-1:0]  cnt_q,        cnt_d;
    logic                     found_q,      found_d;
    logic        [CW-1:0]     best_mag_q,   best_mag_d;
    logic        [ADDR_W-1:0] best_idx_q,   best_idx_d;
    logic signed [DATA_W-1:0] best_amp_q,   best_amp_d;
    logic        [CW-1:0]     thr_q,        thr_d;
    logic                     peak_valid_q, peak_valid_d;
    logic        [ADDR_W-1:0] peak_addr_q,  peak_addr_d;
    logic signed [DATA_W-1:0] peak_amp_q,   peak_amp_d;

    logic                     cand;
    logic                     found_now;
    logic        [CW-1:0]     best_now;
    logic        [ADDR_W-1:0] idx_now;
    logic signed [DATA_W-1:0] amp_now;
    logic        [CW:0]       thr_sum;
    logic        [CW-1:0]     thr_avg;
    logic        [CW-1:0]     thr_dec;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        found_d      = found_q;
        best_mag_d   = best_mag_q;
        best_idx_d   = best_idx_q;
        best_amp_d   = best_amp_q;
        thr_d        = thr_q;
        peak_valid_d = 1'b0;
        peak_addr_d  = peak_addr_q;
        peak_amp_d   = peak_amp_q;

        cand      = (mag_q >= (thr_q >> 1)) && (mag_q > best_mag_q);
        // Window-closing coefficient is folded in before the decision.
        found_now = found_q | cand;
        best_now  = cand ? mag_q     : best_mag_q;
        idx_now   = cand ? blk_idx_q : best_idx_q;
        amp_now   = cand ? blk_max_q : best_amp_q;
        thr_sum   = {1'b0, thr_q} + {1'b0, best_now};
        thr_avg   = thr_sum[CW:1];
        thr_dec   = thr_q - (thr_q >> 2);

        if (coef_valid_q) begin
            unique case (state_q)
                StSearch: begin
                    if (cand) begin
                        found_d    = 1'b1;
                        best_mag_d = mag_q;
                        best_idx_d = blk_idx_q;
                        best_amp_d = blk_max_q;
                    end
                    if (cnt_q == WIN_LAST) begin
                        if (found_now) begin
                            peak_valid_d = 1'b1;
                            peak_addr_d  = idx_now;
                            peak_amp_d   = amp_now;
                            thr_d        = (thr_avg < THR_MIN) ? THR_MIN : thr_avg;
                            if (REFRACT_BLOCKS > 0) begin
                                state_d = StRefract;
                            end
                        end else begin
                            thr_d = (thr_dec < THR_MIN) ? THR_MIN : thr_dec;
                        end
                        cnt_d      = '0;
                        found_d    = 1'b0;
                        best_mag_d = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                StRefract: begin
                    if (cnt_q == REF_LAST) begin
                        state_d = StSearch;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = StSearch;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clock_iht) begin
        if (reset) begin
            state_q      <= StSearch;
            cnt_q        <= '0;
            found_q      <= 1'b0;
            best_mag_q   <= '0;
            best_idx_q   <= '0;
            best_amp_q   <= '0;
            thr_q        <= THR_RST;
            peak_valid_q <= 1'b0;
            peak_addr_q  <= '0;
            peak_amp_q   <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            found_q      <= found_d;
            best_mag_q   <= best_mag_d;
            best_idx_q   <= best_idx_d;
            best_amp_q   <= best_amp_d;
            thr_q        <= thr_d;
            peak_valid_q <= peak_valid_d;
            peak_addr_q  <= peak_addr_d;
            peak_amp_q   <= peak_amp_d;
        end
    end

    assign coef_valid = coef_valid_q;
    assign coef       = coef_q;
    assign peak_valid = peak_valid_q;
    assign peak_addr  = peak_addr_q;
    assign peak_amp   = peak_amp_q;
    assign thr        = thr_q;

endmodule
